// File: rtl/btn_pkg.sv
// Shared types and timing defaults for the push-button front end.
// The channel state enum and the counter-width helper live here.
package btn_pkg;

  typedef enum logic [1:0] {ARM, IDLE, HELD, REPEAT} btn_state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 500_000;
  localparam int DEF_REPEAT_DELAY    = 25_000_000;
  localparam int DEF_REPEAT_PERIOD   = 10_000_000;

  // Smallest width that holds the largest of the three timing constants.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Button-side signal bundle: raw active-low inputs, conditioned pulses and levels, channel states.
// master drives the raw buttons; slave is the conditioner.
interface button_conditioner_if;
  logic                  move_n;
  logic                  select_n;
  logic                  move_pulse;
  logic                  select_pulse;
  logic                  move_held;
  logic                  select_held;
  btn_pkg::btn_state_t   move_state;
  btn_pkg::btn_state_t   select_state;

  modport master (
    output move_n, select_n,
    input  move_pulse, select_pulse, move_held, select_held, move_state, select_state
  );

  modport slave (
    input  move_n, select_n,
    output move_pulse, select_pulse, move_held, select_held, move_state, select_state
  );
endinterface

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-FF synchroniser, stability-counter debounce, press FSM with optional auto-repeat.
// Pulse and level outputs are registered; the FSM reacts to the debounced level as it is accepted.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter int CNT_W           = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD),
  parameter bit REPEAT_EN       = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_n,
  input  logic       hold_freeze,
  output logic       pulse,
  output logic       held,
  output btn_state_t state
);

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic             sync1_q, sync1_d, sync2_q, sync2_d;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic             level_q, level_d;
  logic [CNT_W-1:0] rcnt_q, rcnt_d;
  btn_state_t       state_q, state_d;
  logic             pulse_q, pulse_d;
  logic             s_pressed;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign s_pressed = ~sync2_q;

  always_comb begin
    sync1_d  = btn_n;
    sync2_d  = sync1_q;
    level_d  = level_q;
    db_cnt_d = '0;
    if (s_pressed != level_q) begin
      if (db_cnt_q == DB_LAST) level_d = s_pressed;
      else                     db_cnt_d = sat_inc(db_cnt_q);
    end

    state_d = state_q;
    rcnt_d  = rcnt_q;
    pulse_d = 1'b0;
    unique case (state_q)
      // Arm only once the button is debounced-released with nothing pending,
      // so a press held through reset never fires.
      ARM: begin
        if (level_q || s_pressed) begin
          rcnt_d = '0;
        end else if (rcnt_q == DB_LAST) begin
          rcnt_d  = '0;
          state_d = IDLE;
        end else begin
          rcnt_d = sat_inc(rcnt_q);
        end
      end
      IDLE: begin
        rcnt_d = '0;
        if (level_d && !level_q) begin
          pulse_d = 1'b1;
          state_d = HELD;
        end
      end
      HELD: begin
        if (!level_d) begin
          rcnt_d  = '0;
          state_d = IDLE;
        end else if (REPEAT_EN && !hold_freeze) begin
          if (rcnt_q == DLY_LAST) begin
            pulse_d = 1'b1;
            rcnt_d  = '0;
            state_d = REPEAT;
          end else begin
            rcnt_d = sat_inc(rcnt_q);
          end
        end
      end
      REPEAT: begin
        if (!level_d) begin
          rcnt_d  = '0;
          state_d = IDLE;
        end else if (!hold_freeze) begin
          if (rcnt_q == PER_LAST) begin
            pulse_d = 1'b1;
            rcnt_d  = '0;
          end else begin
            rcnt_d = sat_inc(rcnt_q);
          end
        end
      end
      default: state_d = ARM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      db_cnt_q <= '0;
      level_q  <= 1'b0;
      rcnt_q   <= '0;
      state_q  <= ARM;
      pulse_q  <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      db_cnt_q <= db_cnt_d;
      level_q  <= level_d;
      rcnt_q   <= rcnt_d;
      state_q  <= state_d;
      pulse_q  <= pulse_d;
    end
  end

  assign pulse = pulse_q;
  assign held  = level_q;
  assign state = state_q;

endmodule

// File: rtl/button_conditioner.sv
// Conditions the active-low move and select buttons into single-cycle pulses for the game core.
// Move auto-repeats while held; holding select freezes that repeat.
module button_conditioner
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter int CNT_W           = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)
) (
  input logic                 clk,
  input logic                 rst,
  button_conditioner_if.slave btn
);

  btn_debounce_ch #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD),
    .CNT_W           (CNT_W),
    .REPEAT_EN       (1'b1)
  ) u_move (
    .clk         (clk),
    .rst         (rst),
    .btn_n       (btn.move_n),
    .hold_freeze (btn.select_held),
    .pulse       (btn.move_pulse),
    .held        (btn.move_held),
    .state       (btn.move_state)
  );

  btn_debounce_ch #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD),
    .CNT_W           (CNT_W),
    .REPEAT_EN       (1'b0)
  ) u_select (
    .clk         (clk),
    .rst         (rst),
    .btn_n       (btn.select_n),
    .hold_freeze (1'b0),
    .pulse       (btn.select_pulse),
    .held        (btn.select_held),
    .state       (btn.select_state)
  );

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short timing (debounce 4, delay 20, period 8).
// Pulse cycles are logged by the stepping task and compared against hand-computed cycle numbers.
module tb_button_conditioner;
  import btn_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   mp_q[$];
  int   sp_q[$];

  button_conditioner_if bif();

  button_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (20),
    .REPEAT_PERIOD   (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .btn (bif)
  );

  always #5 clk = ~clk;

  // Advance n clocks; sample #1 after each edge and log pulse cycle numbers.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bif.move_pulse)   mp_q.push_back(cyc);
      if (bif.select_pulse) sp_q.push_back(cyc);
    end
  endtask

  task automatic clear_logs();
    mp_q.delete();
    sp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bif.move_n = 1'b1;
    bif.select_n = 1'b1;
    step(3);
    checks++; if (bif.move_pulse !== 1'b0) begin errors++; $display("FAIL reset_move_pulse: got %0b want 0", bif.move_pulse); end
    checks++; if (bif.select_pulse !== 1'b0) begin errors++; $display("FAIL reset_select_pulse: got %0b want 0", bif.select_pulse); end
    checks++; if (bif.move_held !== 1'b0) begin errors++; $display("FAIL reset_move_held: got %0b want 0", bif.move_held); end
    checks++; if (bif.select_held !== 1'b0) begin errors++; $display("FAIL reset_select_held: got %0b want 0", bif.select_held); end
    checks++; if (bif.move_state !== ARM) begin errors++; $display("FAIL reset_move_state: got %0d want %0d", bif.move_state, ARM); end
    checks++; if (bif.select_state !== ARM) begin errors++; $display("FAIL reset_select_state: got %0d want %0d", bif.select_state, ARM); end
    rst = 1'b0;
    step(10);
    checks++; if (bif.move_state !== IDLE) begin errors++; $display("FAIL arm_move_idle: got %0d want %0d", bif.move_state, IDLE); end
    checks++; if (bif.select_state !== IDLE) begin errors++; $display("FAIL arm_select_idle: got %0d want %0d", bif.select_state, IDLE); end
  endtask

  task automatic test_press();
    int cyc0, r0, got;
    clear_logs();
    cyc0 = cyc;
    bif.move_n = 1'b0;
    step(8);
    got = (mp_q.size() > 0) ? mp_q[0] : -1;
    checks++; if (mp_q.size() != 1) begin errors++; $display("FAIL press_count: got %0d want 1", mp_q.size()); end
    checks++; if (got != cyc0 + 6) begin errors++; $display("FAIL press_cycle: got %0d want %0d", got, cyc0 + 6); end
    checks++; if (bif.move_held !== 1'b1) begin errors++; $display("FAIL press_held: got %0b want 1", bif.move_held); end
    checks++; if (sp_q.size() != 0) begin errors++; $display("FAIL press_no_select: got %0d want 0", sp_q.size()); end
    r0 = cyc;
    bif.move_n = 1'b1;
    step(5);
    checks++; if (bif.move_held !== 1'b1) begin errors++; $display("FAIL release_held_early: cycle %0d got %0b want 1", cyc - r0, bif.move_held); end
    step(1);
    checks++; if (bif.move_held !== 1'b0) begin errors++; $display("FAIL release_held_late: cycle %0d got %0b want 0", cyc - r0, bif.move_held); end
    step(6);
    checks++; if (mp_q.size() != 1) begin errors++; $display("FAIL release_no_pulse: got %0d want 1", mp_q.size()); end
  endtask

  task automatic test_bounce();
    int t, got;
    clear_logs();
    bif.move_n = 1'b0; step(1);
    bif.move_n = 1'b1; step(1);
    bif.move_n = 1'b0; step(1);
    bif.move_n = 1'b1; step(1);
    bif.move_n = 1'b0;
    t = cyc;
    step(10);
    got = (mp_q.size() > 0) ? mp_q[0] : -1;
    checks++; if (mp_q.size() != 1) begin errors++; $display("FAIL bounce_count: got %0d want 1", mp_q.size()); end
    checks++; if (got != t + 6) begin errors++; $display("FAIL bounce_cycle: got %0d want %0d", got, t + 6); end
    bif.move_n = 1'b1;
    step(10);
    checks++; if (bif.move_held !== 1'b0) begin errors++; $display("FAIL bounce_release: got %0b want 0", bif.move_held); end
  endtask

  task automatic test_auto_repeat();
    int a, got;
    int exp_t[5];
    clear_logs();
    a = cyc + 6;
    bif.move_n = 1'b0;
    step(52);
    exp_t = '{a, a + 20, a + 28, a + 36, a + 44};
    checks++; if (mp_q.size() != 5) begin errors++; $display("FAIL repeat_count: got %0d want 5", mp_q.size()); end
    for (int i = 0; i < 5; i++) begin
      got = (i < mp_q.size()) ? mp_q[i] : -1;
      checks++; if (got != exp_t[i]) begin errors++; $display("FAIL repeat_cycle_%0d: got %0d want %0d", i, got, exp_t[i]); end
    end
    // Release now so the debounced fall lands on the same edge as the next tick.
    bif.move_n = 1'b1;
    step(5);
    checks++; if (bif.move_held !== 1'b1) begin errors++; $display("FAIL repeat_held_early: got %0b want 1", bif.move_held); end
    step(1);
    checks++; if (bif.move_held !== 1'b0) begin errors++; $display("FAIL repeat_held_late: got %0b want 0", bif.move_held); end
    checks++; if (bif.move_pulse !== 1'b0) begin errors++; $display("FAIL repeat_tick_suppressed: got %0b want 0", bif.move_pulse); end
    step(10);
    checks++; if (mp_q.size() != 5) begin errors++; $display("FAIL repeat_after_release: got %0d want 5", mp_q.size()); end
  endtask

  task automatic test_freeze();
    int a, got;
    int exp_t[3];
    clear_logs();
    a = cyc + 6;
    bif.move_n = 1'b0;
    step(29);
    bif.select_n = 1'b0;
    step(17);
    got = (sp_q.size() > 0) ? sp_q[0] : -1;
    checks++; if (bif.select_held !== 1'b1) begin errors++; $display("FAIL freeze_select_held: got %0b want 1", bif.select_held); end
    checks++; if (sp_q.size() != 1) begin errors++; $display("FAIL freeze_select_count: got %0d want 1", sp_q.size()); end
    checks++; if (got != a + 29) begin errors++; $display("FAIL freeze_select_cycle: got %0d want %0d", got, a + 29); end
    exp_t = '{a, a + 20, a + 28};
    checks++; if (mp_q.size() != 3) begin errors++; $display("FAIL freeze_move_count: got %0d want 3", mp_q.size()); end
    for (int i = 0; i < 3; i++) begin
      got = (i < mp_q.size()) ? mp_q[i] : -1;
      checks++; if (got != exp_t[i]) begin errors++; $display("FAIL freeze_move_cycle_%0d: got %0d want %0d", i, got, exp_t[i]); end
    end
    bif.select_n = 1'b1;
    step(14);
    got = (mp_q.size() > 3) ? mp_q[3] : -1;
    checks++; if (mp_q.size() != 4) begin errors++; $display("FAIL resume_count: got %0d want 4", mp_q.size()); end
    checks++; if (got != a + 53) begin errors++; $display("FAIL resume_cycle: got %0d want %0d", got, a + 53); end
    checks++; if (bif.select_held !== 1'b0) begin errors++; $display("FAIL resume_select_held: got %0b want 0", bif.select_held); end
    bif.move_n = 1'b1;
    step(12);
    checks++; if (mp_q.size() != 4) begin errors++; $display("FAIL freeze_release_move: got %0d want 4", mp_q.size()); end
    checks++; if (sp_q.size() != 1) begin errors++; $display("FAIL freeze_release_select: got %0d want 1", sp_q.size()); end
  endtask

  task automatic test_simultaneous();
    int cyc0, gm, gs;
    clear_logs();
    cyc0 = cyc;
    bif.move_n = 1'b0;
    bif.select_n = 1'b0;
    step(8);
    gm = (mp_q.size() == 1) ? mp_q[0] : -1;
    gs = (sp_q.size() == 1) ? sp_q[0] : -1;
    checks++; if (gm != cyc0 + 6) begin errors++; $display("FAIL simul_move: got %0d (count %0d) want %0d", gm, mp_q.size(), cyc0 + 6); end
    checks++; if (gs != cyc0 + 6) begin errors++; $display("FAIL simul_select: got %0d (count %0d) want %0d", gs, sp_q.size(), cyc0 + 6); end
    bif.move_n = 1'b1;
    bif.select_n = 1'b1;
    step(10);
    checks++; if (mp_q.size() != 1 || sp_q.size() != 1) begin errors++; $display("FAIL simul_release: got %0d/%0d want 1/1", mp_q.size(), sp_q.size()); end
  endtask

  task automatic test_reset_held();
    int p0, got;
    bif.move_n = 1'b0;
    step(8);
    rst = 1'b1;
    #1;
    checks++; if (bif.move_held !== 1'b0) begin errors++; $display("FAIL async_rst_held: got %0b want 0", bif.move_held); end
    checks++; if (bif.move_state !== ARM) begin errors++; $display("FAIL async_rst_state: got %0d want %0d", bif.move_state, ARM); end
    step(3);
    clear_logs();
    rst = 1'b0;
    step(20);
    checks++; if (mp_q.size() != 0) begin errors++; $display("FAIL held_thru_rst_pulse: got %0d want 0", mp_q.size()); end
    checks++; if (bif.move_state !== ARM) begin errors++; $display("FAIL held_thru_rst_state: got %0d want %0d", bif.move_state, ARM); end
    checks++; if (bif.move_held !== 1'b1) begin errors++; $display("FAIL held_thru_rst_level: got %0b want 1", bif.move_held); end
    bif.move_n = 1'b1;
    step(12);
    checks++; if (bif.move_state !== IDLE) begin errors++; $display("FAIL rearm_state: got %0d want %0d", bif.move_state, IDLE); end
    checks++; if (mp_q.size() != 0) begin errors++; $display("FAIL rearm_no_pulse: got %0d want 0", mp_q.size()); end
    p0 = cyc;
    bif.move_n = 1'b0;
    step(8);
    got = (mp_q.size() == 1) ? mp_q[0] : -1;
    checks++; if (got != p0 + 6) begin errors++; $display("FAIL repress_pulse: got %0d (count %0d) want %0d", got, mp_q.size(), p0 + 6); end
    bif.move_n = 1'b1;
    step(10);
  endtask

  initial begin
    rst = 1'b1;
    bif.move_n = 1'b1;
    bif.select_n = 1'b1;
    test_reset();
    test_press();
    test_bounce();
    test_auto_repeat();
    test_freeze();
    test_simultaneous();
    test_reset_held();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
